// File: rtl/cell4_bist_ctrl.sv
// BIST controller for 4-input OAI22-class cells: drives exhaustive or LFSR patterns,
// waits a settle time, checks Y against a golden model and compacts Y into a MISR.
module cell4_bist_ctrl #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NPAT       = 64,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic             ABORT,
  input  logic             MODE,
  input  logic             Y_I,
  output logic             A_O,
  output logic             B_O,
  output logic             C_O,
  output logic             D_O,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [15:0]      SIG
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]  SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  LAST_RND    = 8'(NPAT - 1);
  localparam logic [7:0]  LAST_EXH    = 8'd15;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [15:0] MISR_POLY   = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [7:0]       pat_q, pat_d;
  logic [3:0]       settle_q, settle_d;
  logic [3:0]       drive_q, drive_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      sig_q, sig_d;

  logic expected_y;
  logic mismatch;
  logic last_pat;
  logic lfsr_fb;
  logic misr_fb;

  // drive_q is {A,B,C,D}
  assign expected_y = ~((drive_q[3] | drive_q[2]) & (drive_q[1] | drive_q[0]));
  assign mismatch   = (Y_I != expected_y);
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign misr_fb    = sig_q[15] ^ Y_I;
  assign last_pat   = mode_q ? (pat_q == LAST_RND) : (pat_q == LAST_EXH);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    pat_d    = pat_q;
    settle_d = settle_q;
    drive_d  = drive_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fail_d   = fail_q;
    err_d    = err_q;
    sig_d    = sig_q;

    if (state_q != IDLE && ABORT) begin
      // Abort keeps the partial results for inspection.
      state_d = IDLE;
      busy_d  = 1'b0;
      drive_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START && !ABORT) begin
            state_d = APPLY;
            busy_d  = 1'b1;
            sig_d   = 16'd0;
            err_d   = '0;
            fail_d  = 1'b0;
            pat_d   = 8'd0;
            lfsr_d  = SEED;
            mode_d  = MODE;
          end
        end
        APPLY: begin
          drive_d  = mode_q ? lfsr_q[3:0] : pat_q[3:0];
          settle_d = 4'd0;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = SAMPLE;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
          end
          sig_d   = {sig_q[14:0], 1'b0} ^ (misr_fb ? MISR_POLY : 16'd0);
          lfsr_d  = {lfsr_q[6:0], lfsr_fb};
          pat_d   = pat_q + 8'd1;
          state_d = last_pat ? FINISH : APPLY;
        end
        FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          drive_d = 4'd0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          drive_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      pat_q    <= 8'd0;
      settle_q <= 4'd0;
      drive_q  <= 4'd0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= '0;
      sig_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      pat_q    <= pat_d;
      settle_q <= settle_d;
      drive_q  <= drive_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      sig_q    <= sig_d;
    end
  end

  assign {A_O, B_O, C_O, D_O} = drive_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign FAIL    = fail_q;
  assign ERR_CNT = err_q;
  assign SIG     = sig_q;

endmodule

// File: tb/tb_cell4_bist_ctrl.sv
// Bench for cell4_bist_ctrl: a run-level timing/result model is compared with the
// DUT outputs on every falling edge, plus directed literal checks.
`timescale 1ns/1ps
module tb_cell4_bist_ctrl;

  localparam int P    = 4;   // per-pattern period, SETTLE_CYC + 2
  localparam int NRND = 64;

  logic        CLK = 1'b0;
  logic        R = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        MODE = 1'b0;
  logic        Y_I;
  logic        A_O, B_O, C_O, D_O;
  logic        BUSY, DONE, FAIL;
  logic [7:0]  ERR_CNT;
  logic [15:0] SIG;
  logic [3:0]  drv;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int y_kind = 0;   // 0 ideal CUT, 1 stuck-at-0, 2 stuck-at-1

  // Run model: expected per-pattern drive and results after k samples.
  bit          run_valid = 1'b0;
  int          start_cyc = 0;
  int          abort_cyc = 32'h7fff_ffff;
  int          m_n = 16;
  logic [3:0]  m_pat [256];
  int          m_err [257];
  logic [15:0] m_sig [257];

  cell4_bist_ctrl #(
    .SETTLE_CYC(2),
    .NPAT(NRND),
    .LFSR_SEED(8'hA5),
    .ERR_W(8)
  ) dut (
    .CLK(CLK),
    .R(R),
    .START(START),
    .ABORT(ABORT),
    .MODE(MODE),
    .Y_I(Y_I),
    .A_O(A_O),
    .B_O(B_O),
    .C_O(C_O),
    .D_O(D_O),
    .BUSY(BUSY),
    .DONE(DONE),
    .FAIL(FAIL),
    .ERR_CNT(ERR_CNT),
    .SIG(SIG)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign drv = {A_O, B_O, C_O, D_O};
  assign Y_I = (y_kind == 1) ? 1'b0 :
               (y_kind == 2) ? 1'b1 : ~((A_O | B_O) & (C_O | D_O));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic build_model(input bit mode, input int kind);
    logic [7:0]  l;
    logic [15:0] s;
    int          e;
    bit          g;
    bit          y;
    l = 8'hA5;
    s = 16'd0;
    e = 0;
    m_n = mode ? NRND : 16;
    m_err[0] = 0;
    m_sig[0] = 16'd0;
    for (int k = 0; k < m_n; k++) begin
      m_pat[k] = mode ? l[3:0] : 4'(k);
      g = !((m_pat[k][3] | m_pat[k][2]) & (m_pat[k][1] | m_pat[k][0]));
      y = (kind == 0) ? g : (kind == 2);
      if (y != g && e < 255) e++;
      s = {s[14:0], 1'b0} ^ ((s[15] ^ y) ? 16'h1021 : 16'h0000);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      m_err[k + 1] = e;
      m_sig[k + 1] = s;
    end
  endtask

  always @(negedge CLK) begin : compare
    logic [3:0]  e_drv;
    logic        e_busy;
    logic        e_done;
    int          e_err;
    logic [15:0] e_sig;
    int          n;
    int          a;
    int          tot;
    int          s;
    e_drv  = 4'd0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_err  = 0;
    e_sig  = 16'd0;
    if (R && run_valid) begin
      n   = cyc - start_cyc;
      a   = abort_cyc - start_cyc;
      tot = m_n * P;
      if (n >= a) begin
        s = (a - 1) / P;
      end else begin
        e_busy = (n <= tot);
        e_done = (n == tot + 1);
        if (n >= 1 && n <= tot) e_drv = m_pat[(n - 1) / P];
        s = n / P;
      end
      if (s > m_n) s = m_n;
      e_err = m_err[s];
      e_sig = m_sig[s];
    end
    chk("drive", 32'(drv), 32'(e_drv));
    chk("busy", 32'(BUSY), 32'(e_busy));
    chk("done", 32'(DONE), 32'(e_done));
    chk("err_cnt", 32'(ERR_CNT), 32'(e_err));
    chk("fail", 32'(FAIL), 32'(e_err != 0));
    chk("sig", 32'(SIG), 32'(e_sig));
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_run(input bit mode, input int kind);
    MODE   = mode;
    y_kind = kind;
    START  = 1'b1;
    tick(1);
    START = 1'b0;
    build_model(mode, kind);
    start_cyc = cyc;
    abort_cyc = 32'h7fff_ffff;
    run_valid = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!DONE && k < 3000) begin
      tick(1);
      k++;
    end
    chk({name, "_done_seen"}, 32'(DONE), 32'd1);
    $display("run %s mode=%0d cut=%0d cycles=%0d err=%0d fail=%0d sig=%04h",
             name, MODE, y_kind, cyc - start_cyc, ERR_CNT, FAIL, SIG);
  endtask

  initial begin
    tick(2);
    chk("rst_sig", 32'(SIG), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    R = 1'b1;
    tick(2);

    // Exhaustive, ideal CUT; START while busy and a MODE change are ignored.
    start_run(1'b0, 0);
    MODE = 1'b1;
    tick(10);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    wait_done("exh_ideal");
    chk("exh_len", 32'(cyc - start_cyc), 32'd65);
    chk("exh_sig", 32'(SIG), 32'h8AE8);
    chk("exh_err", 32'(ERR_CNT), 32'd0);
    chk("exh_fail", 32'(FAIL), 32'd0);

    // Stuck-at faults, each started in the cycle after DONE.
    start_run(1'b0, 1);
    wait_done("exh_sa0");
    chk("sa0_err", 32'(ERR_CNT), 32'd7);
    chk("sa0_fail", 32'(FAIL), 32'd1);
    start_run(1'b0, 2);
    wait_done("exh_sa1");
    chk("sa1_err", 32'(ERR_CNT), 32'd9);
    chk("sa1_fail", 32'(FAIL), 32'd1);

    // Random mode: first drives follow the LFSR from seed A5.
    start_run(1'b1, 0);
    tick(1);
    chk("rnd_pat0", 32'(drv), 32'h5);
    tick(P);
    chk("rnd_pat1", 32'(drv), 32'hA);
    tick(P);
    chk("rnd_pat2", 32'(drv), 32'h5);
    tick(P);
    chk("rnd_pat3", 32'(drv), 32'hA);
    wait_done("rnd_ideal");
    chk("rnd_len", 32'(cyc - start_cyc), 32'd257);
    chk("rnd_err", 32'(ERR_CNT), 32'd0);

    // Abort during the settle of pattern 5 with a stuck-at-0 CUT.
    start_run(1'b0, 1);
    tick(5 * P + 1);
    ABORT = 1'b1;
    abort_cyc = cyc + 1;
    tick(1);
    ABORT = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_drive", 32'(drv), 32'd0);
    tick(5);
    chk("abort_err_hold", 32'(ERR_CNT), 32'd5);
    chk("abort_fail_hold", 32'(FAIL), 32'd1);
    $display("run abort_p5 err=%0d fail=%0d sig=%04h", ERR_CNT, FAIL, SIG);

    // Restart clears results; then abort in FINISH suppresses DONE.
    start_run(1'b0, 0);
    chk("restart_err", 32'(ERR_CNT), 32'd0);
    chk("restart_fail", 32'(FAIL), 32'd0);
    tick(64);
    ABORT = 1'b1;
    abort_cyc = cyc + 1;
    tick(1);
    ABORT = 1'b0;
    chk("abort_fin_done", 32'(DONE), 32'd0);
    chk("abort_fin_busy", 32'(BUSY), 32'd0);
    chk("abort_fin_sig", 32'(SIG), 32'h8AE8);
    $display("run abort_finish busy=%0d done=%0d sig=%04h", BUSY, DONE, SIG);

    // START together with ABORT in IDLE does nothing.
    START = 1'b1;
    ABORT = 1'b1;
    tick(1);
    START = 1'b0;
    ABORT = 1'b0;
    tick(2);
    chk("start_abort_idle", 32'(BUSY), 32'd0);

    // Asynchronous reset in the middle of a settle window.
    start_run(1'b0, 0);
    tick(5 * P + 2);
    #2;
    R = 1'b0;
    run_valid = 1'b0;
    #1;
    chk("rst_mid_drive", 32'(drv), 32'd0);
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_sig", 32'(SIG), 32'd0);
    chk("rst_mid_err", 32'(ERR_CNT), 32'd0);
    tick(2);
    R = 1'b1;
    tick(2);
    chk("post_rst_idle", 32'(BUSY), 32'd0);
    $display("run reset_mid busy=%0d sig=%04h", BUSY, SIG);

    start_run(1'b0, 0);
    wait_done("after_reset");
    chk("after_rst_sig", 32'(SIG), 32'h8AE8);
    chk("after_rst_err", 32'(ERR_CNT), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
